npu_core: RTL and testbench

- Single-shot 10x10 neural-processing pipeline.
- On start, computes the matrix product C = A x A of the 16-bit signed input matrix A on an output-stationary 10x10 systolic array.
- Applies a leaky ReLU to C, then normalizes the result to unsigned 8 bits by a data-dependent right shift.
- Top-level accelerator block, driven by a controller that pulses start and waits for done.

---
 rtl/npu_if.sv | 18 +
 rtl/npu_core.sv | 167 ++++++++++++++++
 tb/tb_npu_core.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_if.sv
// npu_if: controller <-> npu_core bundle.
//   start        : controller requests a new job (one-cycle pulse)
//   input_matrix : operand A, [row][col], signed DW bits
//   done         : core holds the result valid
//   final_output : normalized 8-bit result, [row][col]
// master = controller side, slave = core side.
interface npu_if #(
  parameter int N  = 10,
  parameter int DW = 16
);
  logic                 start;
  logic signed [DW-1:0] input_matrix [N][N];
  logic                 done;
  logic [7:0]           final_output [N][N];

  modport master (output start, output input_matrix, input done, input final_output);
  modport slave  (input start, input input_matrix, output done, output final_output);
endinterface

// File: rtl/npu_core.sv
// npu_core: single-shot C = A x A on an output-stationary NxN systolic array,
// followed by leaky ReLU and a data-dependent right shift to unsigned 8 bits.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : npu_if slave (start / input_matrix in, done / final_output out)
// Timing: start seen at edge T -> done high after edge T+32
// (LOAD 1, COMPUTE 3N-2, RELU 1, SCAN 1, NORM 1).
module npu_core #(
  parameter int N          = 10,
  parameter int DW         = 16,
  parameter int AW         = 36,
  parameter int LEAK_SHIFT = 3
) (
  input logic  clk,
  input logic  rst,
  npu_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, RELU, SCAN, NORM, DONE} state_t;

  localparam int CYCLES = 3 * N - 2;
  localparam int CW     = $clog2(CYCLES + 1);
  localparam int IW     = $clog2(N);
  localparam int SW     = $clog2(AW);

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg;
  logic [SW-1:0]        shift_reg, shift_next;
  logic signed [DW-1:0] mat_reg [N][N];
  logic signed [DW-1:0] a_reg   [N][N];
  logic signed [DW-1:0] b_reg   [N][N];
  logic signed [AW-1:0] acc_reg [N][N];
  logic signed [AW-1:0] r_reg   [N][N];
  logic [7:0]           out_reg [N][N];
  logic signed [DW-1:0] a_edge  [N];
  logic signed [DW-1:0] b_edge  [N];
  logic [AW-2:8]        or_all;
  logic                 systolic_done, norm_done;

  assign systolic_done = (state_reg == COMPUTE) && (cnt_reg == CW'(CYCLES - 1));
  assign norm_done     = (state_reg == NORM);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (bus.start) state_next = LOAD;
      LOAD:    state_next = COMPUTE;
      COMPUTE: if (systolic_done) state_next = RELU;
      RELU:    state_next = SCAN;
      SCAN:    state_next = NORM;
      NORM:    if (norm_done) state_next = DONE;
      DONE:    if (bus.start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Compute-cycle counter and the normalization shift chosen in SCAN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else begin
      if (state_reg == LOAD)         cnt_reg <= '0;
      else if (state_reg == COMPUTE) cnt_reg <= cnt_reg + 1'b1;
      if (state_reg == SCAN)         shift_reg <= shift_next;
    end
  end

  // Private copy of A so the controller may change input_matrix after LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          mat_reg[i][j] <= '0;
    end else if (state_reg == LOAD) begin
      mat_reg <= bus.input_matrix;
    end
  end

  // ---------------- skewed edge feeders ----------------
  // Row gi / column gi enter gi cycles late. k = cnt - gi wraps to a large
  // value (>= N) while cnt < gi, so the single k < N test covers both ends
  // of the live window.
  genvar gi, gj;
  for (gi = 0; gi < N; gi++) begin : g_edge
    logic [CW-1:0] k;
    logic          live;
    assign k    = cnt_reg - CW'(gi);
    assign live = (state_reg == COMPUTE) && (k < CW'(N));
    assign a_edge[gi] = live ? mat_reg[gi][k[IW-1:0]] : '0;
    assign b_edge[gi] = live ? mat_reg[k[IW-1:0]][gi] : '0;
  end

  // ---------------- processing elements ----------------
  for (gi = 0; gi < N; gi++) begin : g_row
    for (gj = 0; gj < N; gj++) begin : g_col
      logic signed [DW-1:0]   a_in, b_in;
      logic signed [2*DW-1:0] prod;

      if (gj == 0) begin : g_left
        assign a_in = a_edge[gi];
      end else begin : g_inner_a
        assign a_in = a_reg[gi][gj-1];
      end
      if (gi == 0) begin : g_top
        assign b_in = b_edge[gj];
      end else begin : g_inner_b
        assign b_in = b_reg[gi-1][gj];
      end

      assign prod = a_in * b_in;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_reg[gi][gj]   <= '0;
          b_reg[gi][gj]   <= '0;
          acc_reg[gi][gj] <= '0;
          r_reg[gi][gj]   <= '0;
          out_reg[gi][gj] <= '0;
        end else begin
          if (state_reg == LOAD) begin
            a_reg[gi][gj]   <= '0;
            b_reg[gi][gj]   <= '0;
            acc_reg[gi][gj] <= '0;
          end else if (state_reg == COMPUTE) begin
            a_reg[gi][gj]   <= a_in;
            b_reg[gi][gj]   <= b_in;
            acc_reg[gi][gj] <= acc_reg[gi][gj] + AW'(prod);
          end
          if (state_reg == RELU)
            r_reg[gi][gj] <= acc_reg[gi][gj][AW-1] ? (acc_reg[gi][gj] >>> LEAK_SHIFT)
                                                   : acc_reg[gi][gj];
          if (state_reg == NORM)
            out_reg[gi][gj] <= r_reg[gi][gj][AW-1] ? 8'd0 : 8'(r_reg[gi][gj] >> shift_reg);
        end
      end
    end
  end

  // The top set bit of the OR of all non-negative r equals the top set bit
  // of their maximum, which is all the shift choice needs. Bits below 8 can
  // never force a shift, so they are left out.
  always_comb begin
    or_all = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (!r_reg[i][j][AW-1]) or_all = or_all | r_reg[i][j][AW-2:8];
  end

  // Top set bit at position p >= 8 needs a shift of p-7 to land in 0..255.
  always_comb begin
    shift_next = '0;
    for (int b = 8; b <= AW - 2; b++)
      if (or_all[b]) shift_next = SW'(b - 7);
  end

  assign bus.done         = (state_reg == DONE);
  assign bus.final_output = out_reg;

endmodule

// File: tb/tb_npu_core.sv
module tb_npu_core;
  localparam int N = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  npu_if #(.N(N), .DW(16)) bus ();

  npu_core #(.N(N), .DW(16), .AW(36), .LEAK_SHIFT(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int     tests_run    = 0;
  int     tests_failed = 0;
  longint a_m     [N][N];
  longint r_m     [N][N];
  int     exp_out [N][N];

  // ---------------- reference model ----------------
  task automatic apply_matrix();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.input_matrix[i][j] = 16'(a_m[i][j]);
  endtask

  task automatic set_all(input longint v);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        a_m[i][j] = v;
  endtask

  task automatic expect_zero();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_out[i][j] = 0;
  endtask

  // Matrix product, floor(c/8) for negatives, max of the non-negative values,
  // smallest shift that brings that max into 0..255.
  task automatic model();
    longint c, m;
    int s;
    m = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c = 0;
        for (int k = 0; k < N; k++) c += a_m[i][k] * a_m[k][j];
        r_m[i][j] = (c >= 0) ? c : -((-c + 7) / 8);
        if (r_m[i][j] > m) m = r_m[i][j];
      end
    s = 0;
    while ((m >> s) > 255) s++;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_out[i][j] = (r_m[i][j] < 0) ? 0 : int'(r_m[i][j] >> s);
  endtask

  function automatic int count_bad(output int bi, output int bj, output int ba);
    int n;
    logic [7:0] v;
    n = 0; bi = 0; bj = 0; ba = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        v = bus.final_output[i][j];
        if (v !== 8'(exp_out[i][j])) begin
          if (n == 0) begin bi = i; bj = j; ba = int'(v); end
          n++;
        end
      end
    return n;
  endfunction

  // Pulse start for one cycle; lat = rising edges after the start edge until done.
  task automatic start_and_wait(output int lat);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad, bi, bj, ba;
    rst = 1'b1; bus.start = 1'b0;
    set_all(0); apply_matrix(); expect_zero();
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_done: got %b want 0", bus.done);
    end
    tests_run++;
    bad = count_bad(bi, bj, ba);
    if (bad !== 0) begin
      tests_failed++; $display("FAIL reset_out: %0d bad, [%0d][%0d]=%0d want %0d", bad, bi, bj, ba, exp_out[bi][bj]);
    end
    rst = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic run_checked(input string name);
    int lat, bad, bi, bj, ba;
    apply_matrix(); model();
    start_and_wait(lat);
    tests_run++;
    if (lat !== 32) begin
      tests_failed++; $display("FAIL %s_latency: got %0d want 32", name, lat);
    end
    tests_run++;
    bad = count_bad(bi, bj, ba);
    if (bad !== 0) begin
      tests_failed++; $display("FAIL %s_out: %0d bad, [%0d][%0d]=%0d want %0d", name, bad, bi, bj, ba, exp_out[bi][bj]);
    end
    $display("[TB] job %s latency=%0d out[0][0]=%0d", name, lat, bus.final_output[0][0]);
  endtask

  task automatic test_zero();
    set_all(0);
    run_checked("zero");
  endtask

  task automatic test_identity();
    set_all(0);
    for (int i = 0; i < N; i++) a_m[i][i] = 16;
    run_checked("identity");
    tests_run++;
    if (bus.final_output[4][4] !== 8'd128) begin
      tests_failed++; $display("FAIL identity_diag: got %0d want 128", bus.final_output[4][4]);
    end
    tests_run++;
    if (bus.final_output[4][5] !== 8'd0) begin
      tests_failed++; $display("FAIL identity_offdiag: got %0d want 0", bus.final_output[4][5]);
    end
  endtask

  task automatic test_ones();
    int bad, bi, bj, ba, drops;
    set_all(1);
    run_checked("ones");
    tests_run++;
    if (bus.final_output[7][2] !== 8'd10) begin
      tests_failed++; $display("FAIL ones_value: got %0d want 10", bus.final_output[7][2]);
    end
    drops = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b1 || count_bad(bi, bj, ba) !== 0) drops++;
    end
    tests_run++;
    if (drops !== 0) begin
      tests_failed++; $display("FAIL ones_hold: %0d unstable cycles want 0", drops);
    end
    $display("[TB] ones held for 20 cycles, unstable=%0d", drops);
  endtask

  task automatic test_negative();
    set_all(0);
    a_m[0][1] = -4; a_m[1][0] = 4;
    run_checked("neg_only");
    a_m[2][2] = 20;
    run_checked("neg_plus");
    tests_run++;
    if (bus.final_output[2][2] !== 8'd200) begin
      tests_failed++; $display("FAIL neg_plus_22: got %0d want 200", bus.final_output[2][2]);
    end
  endtask

  task automatic test_random();
    logic signed [15:0] v;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          case (t % 4)
            0: begin v = 16'($urandom); a_m[i][j] = v; end
            1: a_m[i][j] = longint'($urandom_range(0, 16)) - 8;
            2: a_m[i][j] = longint'($urandom_range(0, 255));
            default: a_m[i][j] = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 100))
                                                                : -longint'($urandom_range(0, 2000));
          endcase
        end
      run_checked($sformatf("random%0d", t));
    end
  endtask

  task automatic test_input_change();
    int lat, bad, bi, bj, ba;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        a_m[i][j] = longint'($urandom_range(0, 400)) - 200;
    apply_matrix(); model();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);  // LOAD edge has passed
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.input_matrix[i][j] = 16'($urandom);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat !== 32) begin
      tests_failed++; $display("FAIL input_change_latency: got %0d want 32", lat);
    end
    tests_run++;
    bad = count_bad(bi, bj, ba);
    if (bad !== 0) begin
      tests_failed++; $display("FAIL input_change_out: %0d bad, [%0d][%0d]=%0d want %0d", bad, bi, bj, ba, exp_out[bi][bj]);
    end
    $display("[TB] job input_change latency=%0d", lat);
  endtask

  task automatic test_reset_mid();
    int bad, bi, bj, ba;
    set_all(1); apply_matrix();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (10) @(negedge clk);  // now in COMPUTE, cycle 10 is next
    rst = 1'b1;
    #1;
    expect_zero();
    tests_run++;
    if (bus.done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_done: got %b want 0", bus.done);
    end
    tests_run++;
    bad = count_bad(bi, bj, ba);
    if (bad !== 0) begin
      tests_failed++; $display("FAIL reset_mid_out: %0d bad, [%0d][%0d]=%0d want 0", bad, bi, bj, ba);
    end
    $display("[TB] reset mid-compute applied");
    @(negedge clk); rst = 1'b0;
    run_checked("after_reset");
  endtask

  task automatic test_start_busy();
    int lat, bad, bi, bj, ba;
    set_all(0);
    for (int i = 0; i < N; i++) a_m[i][i] = 16;
    apply_matrix(); model();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      bus.start = (lat == 10);
    end
    bus.start = 1'b0;
    tests_run++;
    if (lat !== 32) begin
      tests_failed++; $display("FAIL busy_latency: got %0d want 32", lat);
    end
    tests_run++;
    bad = count_bad(bi, bj, ba);
    if (bad !== 0) begin
      tests_failed++; $display("FAIL busy_out: %0d bad, [%0d][%0d]=%0d want %0d", bad, bi, bj, ba, exp_out[bi][bj]);
    end
    $display("[TB] job busy_restart latency=%0d diag=%0d", lat, bus.final_output[0][0]);
  endtask

  task automatic test_back_to_back();
    set_all(1);
    run_checked("back_to_back");
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    test_reset();
    test_zero();
    test_identity();
    test_ones();
    test_negative();
    test_random();
    test_input_change();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
